// File: rtl/spi_master_param.sv
// spi_master_param: parameterised SPI master supporting all four CPOL/CPHA modes,
// selectable bit order and a decoded active-low slave select.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        cpol,
    input  logic                                        cpha,
    input  logic                                        lsb_first,
    input  logic [(NUM_SS > 1 ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
    input  logic [DATA_W-1:0]                           data_in,
    input  logic                                        miso,
    output logic                                        sclk,
    output logic                                        mosi,
    output logic [NUM_SS-1:0]                           ss_n,
    output logic                                        busy,
    output logic                                        done,
    output logic [DATA_W-1:0]                           data_out
);
    localparam int SS_W  = NUM_SS > 1 ? $clog2(NUM_SS) : 1;
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int EDGES = 2 * DATA_W;
    localparam int EC_W  = $clog2(EDGES + 1);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EC_W-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d, tx_shift;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d, sel_n;
    logic                sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic                tc, lead, edge_now, sample, shift;

    always_comb begin
        tc       = div_q == DIV_W'(CLK_DIV - 1);
        lead     = !edge_q[0];
        // sclk toggles at every terminal count from the end of LEAD until all edges are made
        edge_now = tc && (state_q == LEAD || (state_q == XFER && edge_q != EC_W'(EDGES)));
        sample   = edge_now && (lead != cpha_q);
        shift    = edge_now && (cpha_q ? lead && edge_q != '0 : !lead && edge_q != EC_W'(EDGES - 1));
        tx_shift = lsb_q ? tx_q >> 1 : tx_q << 1;
        for (int i = 0; i < NUM_SS; i++) sel_n[i] = ss_sel != SS_W'(i);
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        ss_n_d     = ss_n_q;
        busy_d     = busy_q;
        done_d     = done_q;
        data_out_d = data_out_q;
        div_d      = (state_q == IDLE || state_q == DONE || tc) ? '0 : div_q + 1'b1;
        sclk_d     = edge_now ? !sclk_q : sclk_q;
        edge_d     = edge_now ? edge_q + 1'b1 : edge_q;
        rx_d       = sample ? (lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso}) : rx_q;
        tx_d       = shift ? tx_shift : tx_q;
        mosi_d     = shift ? (lsb_q ? tx_shift[0] : tx_shift[DATA_W-1]) : mosi_q;
        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                ss_n_d = '1;
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    state_d = LEAD;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    tx_d    = data_in;
                    mosi_d  = lsb_first ? data_in[0] : data_in[DATA_W-1];
                    ss_n_d  = sel_n;
                    busy_d  = 1'b1;
                    edge_d  = '0;
                    rx_d    = '0;
                end
            end
            LEAD:  state_d = tc ? XFER : LEAD;
            XFER:  state_d = (tc && edge_q == EC_W'(EDGES)) ? TRAIL : XFER;
            TRAIL: begin
                if (tc) begin
                    state_d    = DONE;
                    ss_n_d     = '1;
                    done_d     = 1'b1;
                    data_out_d = rx_q;
                    mosi_d     = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                sclk_d  = cpol;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            ss_n_q     <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter DATA_W, default 8, word length in bits (>=2).
REQ-002 Parameter CLK_DIV, default 4, sclk half-period in clk cycles (>=1).
REQ-003 Parameter NUM_SS, default 1, number of slave-select lines (>=1).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  transfer request; sampled only while busy=0.
REQ-007 cpol  input  1  sclk idle level; latched at accept.
REQ-008 cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept.
REQ-009 lsb_first  input  1  0 = MSB first, 1 = LSB first; latched at accept.
REQ-010 ss_sel  input  $clog2(NUM_SS) (min 1)  target slave index; latched at accept.
REQ-011 data_in  input  DATA_W  word to transmit; latched at accept.
REQ-012 miso  input  1  serial data from slave.
REQ-013 sclk  output  1  serial clock.
REQ-014 mosi  output  1  serial data to slave.
REQ-015 ss_n  output  NUM_SS  active-low slave selects.
REQ-016 busy  output  1  high from the cycle after accept through the DONE cycle.
REQ-017 done  output  1  one-cycle pulse; data_out valid.
REQ-018 data_out  output  DATA_W  last received word; held until next done.

Function
REQ-019 FSM states IDLE, LEAD, XFER, TRAIL, DONE; IDLE->LEAD on start=1 in IDLE (accept cycle T).
REQ-020 Half-period counter counts CLK_DIV cycles; each state transition and sclk edge occurs at counter terminal count.
REQ-021 LEAD lasts CLK_DIV cycles: ss_n[ss_sel]=0, sclk=cpol, first bit on mosi from cycle T+1.
REQ-022 XFER lasts 2*DATA_W*CLK_DIV cycles; sclk toggles every CLK_DIV cycles, producing exactly DATA_W leading and DATA_W trailing edges.
REQ-023 cpha=0: miso sampled at each leading edge; next bit driven on mosi at each trailing edge except the last.
REQ-024 cpha=1: next bit driven on mosi at each leading edge (first leading edge drives bit 0 of sequence); miso sampled at each trailing edge.
REQ-025 Bit order: lsb_first=0 -> data_in[DATA_W-1] first, received bits enter at LSB; lsb_first=1 -> data_in[0] first, received bits enter at MSB.
REQ-026 TRAIL lasts CLK_DIV cycles, sclk=cpol, ss_n still asserted; then DONE.
REQ-027 DONE lasts 1 cycle: ss_n all 1, done=1, data_out loaded with received word, busy=1; next state IDLE.
REQ-028 Total: accept at T -> done at T+1+CLK_DIV*(2*DATA_W+2); busy low the cycle after done.
REQ-029 start while busy=1 is ignored, not queued; start in the DONE cycle ignored.
REQ-030 Changes of cpol/cpha/lsb_first/ss_sel/data_in after accept have no effect on the current transfer.
REQ-031 In IDLE sclk follows registered cpol input, mosi=0, ss_n all 1.
REQ-032 Only one ss_n bit low at any time; ss_sel >= NUM_SS selects no slave (transfer still runs).

Reset
REQ-033 rst=0 at a clock edge: state IDLE, counters 0, sclk=0, mosi=0, ss_n all 1, busy=0, done=0, data_out=0.
REQ-034 Reset mid-transfer aborts immediately with REQ-033 values; no done pulse; data_out=0.
REQ-035 rst has priority over start in the same cycle.

Verification
REQ-036 DATA_W=8, CLK_DIV=2, mode 0, miso looped to mosi, data_in=0xA5 -> done at T+37, data_out=0xA5, 8 rising sclk edges.
REQ-037 Mode 3 (cpol=1,cpha=1), miso=1 constant, data_in=0x3C -> sclk idles 1, mosi sequence 0,0,1,1,1,1,0,0, data_out=0xFF.
REQ-038 lsb_first=1, data_in=0x01, miso loopback -> first mosi bit 1, data_out=0x01.
REQ-039 NUM_SS=4, ss_sel=2 -> only ss_n[2] low during LEAD..TRAIL, ss_n=4'hF in DONE.
REQ-040 start pulsed mid-XFER -> ignored, single done; rst=0 mid-XFER -> next cycle ss_n all 1, busy=0, no done.
